// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - MEM stage state encodings, size codes and size clamp helper
package mem_stage_lsu_pkg;

  localparam logic [2:0] MEM_ST_IDLE  = 3'd0;
  localparam logic [2:0] MEM_ST_REQ   = 3'd1;
  localparam logic [2:0] MEM_ST_RSP   = 3'd2;
  localparam logic [2:0] MEM_ST_DONE  = 3'd3;
  localparam logic [2:0] MEM_ST_DRAIN = 3'd4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Access sizes wider than the datapath collapse to the full width.
  function automatic logic [1:0] clamp_size(input logic [1:0] size, input logic [1:0] lb);
    return (size > lb) ? lb : size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load extract/extend, store replicate and byte-enable generation
module mem_lane_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                   size,
  input  logic [$clog2(DATA_W/8)-1:0]  lane,
  input  logic                         sext,
  input  logic [DATA_W-1:0]            rdata,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            ld_data,
  output logic [DATA_W-1:0]            st_data,
  output logic [DATA_W/8-1:0]          st_be
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DATA_W);

  logic [LB-1:0]     lane_eff;
  logic [DATA_W-1:0] shifted;
  logic [IW-1:0]     sign_idx;
  logic              sign_bit;
  int                nbytes;
  int                nbits;
  int                lane_i;

  always_comb begin
    nbytes   = 1 << size;
    nbits    = nbytes * 8;
    // Address bits below the access size are ignored, never faulted here.
    lane_eff = lane & ~LB'(nbytes - 1);
    lane_i   = int'(lane_eff);
    shifted  = rdata >> (lane_i * 8);
    sign_idx = IW'(nbits - 1);
    sign_bit = sext & shifted[sign_idx];
    ld_data  = '0;
    st_data  = '0;
    st_be    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_data[i] = (i < nbits) ? shifted[i] : sign_bit;
      st_data[i] = wdata[IW'(i & (nbits - 1))];
    end
    for (int b = 0; b < NB; b++) begin
      st_be[b] = (b >= lane_i) && (b < lane_i + nbytes);
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - single-slot MEM stage with req/gnt/rvalid memory handshake (option: MEM_STAGE_ALIGN_EXC_EN)
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [PC_W-1:0]      ex_pc,
  input  logic                 ex_ld,
  input  logic                 ex_st,
  input  logic [1:0]           ex_size,
  input  logic                 ex_sext,
  input  logic [DATA_W-1:0]    ex_result,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic                 ex_rf_we,
  input  logic [4:0]           ex_rf_waddr,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [DATA_W/8-1:0]  dm_be,
  output logic [DATA_W-1:0]    dm_wdata,
  input  logic                 dm_gnt,
  input  logic                 dm_rvalid,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [PC_W-1:0]      wb_pc,
  output logic                 wb_rf_we,
  output logic [4:0]           wb_rf_waddr,
  output logic [DATA_W-1:0]    wb_rf_wdata,
  output logic                 wb_exc
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  logic [2:0]        state;
  logic [PC_W-1:0]   s_pc;
  logic              s_ld, s_st, s_sext, s_rf_we, s_exc;
  logic [1:0]        s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_data;
  logic [4:0]        s_waddr;

  logic [1:0]        ex_sz;
  logic              ex_mem, ex_st_eff, ex_misalign, xfer;
  logic [DATA_W-1:0] ld_data, st_data;
  logic [NB-1:0]     st_be;

  assign ex_sz     = clamp_size(ex_size, 2'(LB));
  assign ex_mem    = ex_ld | ex_st;
  assign ex_st_eff = ex_st & ~ex_ld;

`ifdef MEM_STAGE_ALIGN_EXC_EN
  assign ex_misalign = ex_mem && ((ex_result[LB-1:0] & LB'((1 << ex_sz) - 1)) != '0);
`else
  assign ex_misalign = 1'b0;
`endif

  assign ex_ready = (state == MEM_ST_IDLE) || ((state == MEM_ST_DONE) && wb_ready);
  assign xfer     = ex_valid && ex_ready && !flush;
  assign dm_req   = (state == MEM_ST_REQ) && !flush;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (s_size),
    .lane    (s_addr[LB-1:0]),
    .sext    (s_sext),
    .rdata   (dm_rdata),
    .wdata   (s_wdata),
    .ld_data (ld_data),
    .st_data (st_data),
    .st_be   (st_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MEM_ST_IDLE;
      s_pc    <= '0;
      s_ld    <= 1'b0;
      s_st    <= 1'b0;
      s_sext  <= 1'b0;
      s_rf_we <= 1'b0;
      s_exc   <= 1'b0;
      s_size  <= '0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_data  <= '0;
      s_waddr <= '0;
    end else begin
      case (state)
        MEM_ST_REQ: begin
          if (flush) state <= MEM_ST_IDLE;
          else if (dm_gnt) state <= s_st ? MEM_ST_DONE : MEM_ST_RSP;
        end
        MEM_ST_RSP: begin
          if (flush) begin
            state <= dm_rvalid ? MEM_ST_IDLE : MEM_ST_DRAIN;
          end else if (dm_rvalid) begin
            state  <= MEM_ST_DONE;
            s_data <= ld_data;
          end
        end
        // A flushed load still owes one response; swallow it before going idle.
        MEM_ST_DRAIN: if (dm_rvalid) state <= MEM_ST_IDLE;
        MEM_ST_DONE:  if (flush || wb_ready) state <= MEM_ST_IDLE;
        default:      state <= MEM_ST_IDLE;
      endcase
      if (xfer) begin
        state   <= (ex_mem && !ex_misalign) ? MEM_ST_REQ : MEM_ST_DONE;
        s_pc    <= ex_pc;
        s_ld    <= ex_ld;
        s_st    <= ex_st_eff;
        s_sext  <= ex_sext;
        s_size  <= ex_sz;
        s_addr  <= ex_result[ADDR_W-1:0];
        s_wdata <= ex_wdata;
        s_waddr <= ex_rf_waddr;
        s_rf_we <= ex_rf_we && !ex_st_eff && !ex_misalign;
        s_exc   <= ex_misalign;
        s_data  <= ex_misalign ? DATA_W'(ex_result[ADDR_W-1:0]) : ex_result;
      end
    end
  end

  assign dm_we       = s_st;
  assign dm_addr     = s_addr & ~ADDR_W'(NB - 1);
  assign dm_be       = s_ld ? '1 : (s_st ? st_be : '0);
  assign dm_wdata    = st_data;
  assign wb_valid    = (state == MEM_ST_DONE);
  assign wb_pc       = s_pc;
  assign wb_rf_we    = s_rf_we;
  assign wb_rf_waddr = s_waddr;
  assign wb_rf_wdata = s_data;
  assign wb_exc      = s_exc;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized and directed bench for mem_stage_lsu against a transaction-level model
module tb_mem_stage_lsu;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        ex_valid = 1'b0, ex_ld = 1'b0, ex_st = 1'b0, ex_sext = 1'b0, ex_rf_we = 1'b0;
  logic [31:0] ex_pc = '0, ex_result = '0, ex_wdata = '0;
  logic [1:0]  ex_size = '0;
  logic [4:0]  ex_rf_waddr = '0;
  logic        ex_ready, dm_req, dm_we, wb_valid, wb_rf_we, wb_exc;
  logic [31:0] dm_addr, dm_wdata, wb_pc, wb_rf_wdata;
  logic [3:0]  dm_be;
  logic [4:0]  wb_rf_waddr;
  logic        dm_gnt = 1'b0, dm_rvalid = 1'b0, wb_ready = 1'b0;
  logic [31:0] dm_rdata = '0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_ld(ex_ld), .ex_st(ex_st),
    .ex_size(ex_size), .ex_sext(ex_sext), .ex_result(ex_result), .ex_wdata(ex_wdata),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .wb_exc(wb_exc)
  );

  typedef struct {
    logic [31:0] pc, res, wd, rd;
    logic        ld, st, sext, we, seen, iss;
    logic [1:0]  sz;
    logic [4:0]  wa;
    int          t_acc, t_evt;
  } ins_t;

  ins_t        inq[$], expq[$];
  logic [31:0] done_wd[$], done_addr[$], done_dwd[$];
  logic [3:0]  done_be[$];
  logic        done_exc[$];
  int n_cmp = 0, n_err = 0, cyc = 1;
  int ev_pct = 100, gnt_pct = 100, wb_pct = 100, rv_min = 0, rv_max = 0;
  int rv_cnt = 0;
  logic rv_pend = 1'b0, rdy_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: rules of the stage expressed as plain byte arithmetic.
  function automatic int nbytes(input logic [1:0] s);
    return (s > 2'd2) ? 4 : (1 << s);
  endfunction
  function automatic int lane_of(input ins_t t);
    int nb = nbytes(t.sz);
    return int'(t.res[1:0]) / nb * nb;
  endfunction
  function automatic logic misal(input ins_t t);
    logic on;
`ifdef MEM_STAGE_ALIGN_EXC_EN
    on = 1'b1;
`else
    on = 1'b0;
`endif
    return on && (t.ld || t.st) && (int'(t.res[1:0]) % nbytes(t.sz) != 0);
  endfunction
  function automatic logic mem_op(input ins_t t);
    return (t.ld || t.st) && !misal(t);
  endfunction
  function automatic logic [31:0] exp_wd(input ins_t t);
    longint v;
    int nb = nbytes(t.sz);
    if (misal(t) || !t.ld) return t.res;
    v = longint'(t.rd >> (8 * lane_of(t))) & ((longint'(1) << (8 * nb)) - 1);
    if (t.sext && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction
  function automatic logic [3:0] exp_be(input ins_t t);
    if (t.ld) return 4'hf;
    return 4'(((1 << nbytes(t.sz)) - 1) << lane_of(t));
  endfunction
  function automatic logic [31:0] exp_sdata(input ins_t t);
    logic [31:0] w = '0;
    int nb = nbytes(t.sz);
    logic [31:0] m = 32'((64'd1 << (8 * nb)) - 1);
    for (int k = 0; k < 4 / nb; k++) w = w | ((t.wd & m) << (8 * nb * k));
    return w;
  endfunction

  function automatic ins_t mk(input logic ld, input logic st, input logic [1:0] sz, input logic sx,
                              input logic [31:0] res, input logic [31:0] wd, input logic [31:0] rd);
    ins_t t;
    t.pc = $urandom; t.res = res; t.wd = wd; t.rd = rd; t.ld = ld; t.st = st; t.sext = sx;
    t.we = 1'b1; t.sz = sz; t.wa = 5'($urandom_range(31));
    t.seen = 1'b0; t.iss = 1'b0; t.t_acc = 0; t.t_evt = 0;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int k = $urandom_range(3);
    t = mk(k == 1 || k == 3, k >= 2, 2'($urandom_range(3)), 1'($urandom_range(1)),
           $urandom, $urandom, $urandom);
    t.we = 1'($urandom_range(1));
    return t;
  endfunction

  task automatic step();
    ins_t t;
    @(negedge clk);
    wb_ready  = ($urandom_range(99) < wb_pct);
    dm_gnt    = ($urandom_range(99) < gnt_pct);
    dm_rvalid = 1'b0;
    dm_rdata  = $urandom;
    if (rv_pend && rv_cnt == 0 && expq.size() > 0) begin
      dm_rvalid = 1'b1;
      dm_rdata  = expq[0].rd;
    end
    ex_valid = (inq.size() > 0) && ($urandom_range(99) < ev_pct);
    if (inq.size() > 0) begin
      ex_pc = inq[0].pc; ex_ld = inq[0].ld; ex_st = inq[0].st; ex_size = inq[0].sz;
      ex_sext = inq[0].sext; ex_result = inq[0].res; ex_wdata = inq[0].wd;
      ex_rf_we = inq[0].we; ex_rf_waddr = inq[0].wa;
    end
    #1;
    if (rdy_chk) check("b2b_rdy", 64'(ex_ready), 64'd1);
    if (wb_valid) begin
      if (expq.size() == 0) check("wb_spur", 64'(wb_valid), 64'd0);
      else begin
        t = expq[0];
        if (!t.seen) begin
          check("wb_lat", 64'(cyc), 64'((mem_op(t) ? t.t_evt : t.t_acc) + 1));
          t.seen = 1'b1;
          expq[0] = t;
        end
        check("wb_pc", 64'(wb_pc), 64'(t.pc));
        check("wb_we", 64'(wb_rf_we), 64'(t.we && !(t.st && !t.ld) && !misal(t)));
        check("wb_wa", 64'(wb_rf_waddr), 64'(t.wa));
        check("wb_wd", 64'(wb_rf_wdata), 64'(exp_wd(t)));
        check("wb_exc", 64'(wb_exc), 64'(misal(t)));
        if (wb_ready) begin
          done_wd.push_back(wb_rf_wdata);
          done_exc.push_back(wb_exc);
          void'(expq.pop_front());
        end
      end
    end
    if (dm_rvalid) begin
      rv_pend = 1'b0;
      if (expq.size() > 0) begin t = expq[0]; t.t_evt = cyc; expq[0] = t; end
    end else if (rv_pend) rv_cnt--;
    if (dm_req) begin
      if (expq.size() == 0 || !mem_op(expq[0]) || expq[0].iss) check("req_spur", 64'(dm_req), 64'd0);
      else begin
        t = expq[0];
        check("dm_we", 64'(dm_we), 64'(t.st && !t.ld));
        check("dm_addr", 64'(dm_addr), 64'(t.res & ~32'h3));
        check("dm_be", 64'(dm_be), 64'(exp_be(t)));
        if (t.st && !t.ld) check("dm_wd", 64'(dm_wdata), 64'(exp_sdata(t)));
        if (dm_gnt) begin
          t.iss = 1'b1; t.t_evt = cyc; expq[0] = t;
          done_addr.push_back(dm_addr); done_be.push_back(dm_be); done_dwd.push_back(dm_wdata);
          if (t.ld) begin rv_pend = 1'b1; rv_cnt = $urandom_range(rv_max, rv_min); end
        end
      end
    end
    if (ex_valid && ex_ready) begin
      t = inq.pop_front();
      t.t_acc = cyc;
      expq.push_back(t);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int max_cyc);
    int n = 0;
    while ((inq.size() > 0 || expq.size() > 0) && n < max_cyc) begin step(); n++; end
    check("drain", 64'(inq.size() + expq.size()), 64'd0);
  endtask

  task automatic clear_done();
    done_wd.delete(); done_exc.delete(); done_addr.delete(); done_be.delete(); done_dwd.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ex_ready), 64'd1);
    check("rst_req", 64'(dm_req), 64'd0);
    check("rst_wbv", 64'(wb_valid), 64'd0);
    check("rst_outs", 64'({dm_we, dm_be, dm_addr, dm_wdata}), 64'd0);
    check("rst_wb", 64'({wb_rf_we, wb_exc, wb_rf_waddr, wb_rf_wdata, wb_pc}), 64'd0);
    rst_n = 1'b1;

    // Back-to-back ALU ops, one result per cycle.
    rdy_chk = 1'b1;
    for (int i = 0; i < 6; i++) inq.push_back(mk(0, 0, 2'd2, 0, $urandom, 0, 0));
    run(20);
    rdy_chk = 1'b0;

    // Byte loads from a high lane, signed and unsigned.
    clear_done();
    inq.push_back(mk(1, 0, 2'd0, 1, 32'h1003, 0, 32'h80FF_FF12));
    inq.push_back(mk(1, 0, 2'd0, 0, 32'h1003, 0, 32'h80FF_FF12));
    run(40);
    if (done_wd.size() == 2) begin
      check("lb", 64'(done_wd[0]), 64'hFFFF_FF80);
      check("lbu", 64'(done_wd[1]), 64'h80);
    end else check("lb_cnt", 64'(done_wd.size()), 64'd2);

    // Halfword store in the upper half.
    clear_done();
    inq.push_back(mk(0, 1, 2'd1, 0, 32'h2002, 32'h1234, 0));
    run(40);
    if (done_addr.size() == 1) begin
      check("sh_addr", 64'(done_addr[0]), 64'h2000);
      check("sh_be", 64'(done_be[0]), 64'hC);
      check("sh_wd", 64'(done_dwd[0]), 64'h1234_1234);
    end else check("sh_cnt", 64'(done_addr.size()), 64'd1);

    // Misaligned word load.
    clear_done();
    inq.push_back(mk(1, 0, 2'd2, 0, 32'h0006, 0, $urandom));
    run(40);
`ifdef MEM_STAGE_ALIGN_EXC_EN
    check("lw_noreq", 64'(done_addr.size()), 64'd0);
    if (done_wd.size() == 1) begin
      check("lw_exc", 64'(done_exc[0]), 64'd1);
      check("lw_fault", 64'(done_wd[0]), 64'h6);
    end else check("lw_cnt", 64'(done_wd.size()), 64'd1);
`else
    if (done_addr.size() == 1) check("lw_addr", 64'(done_addr[0]), 64'h4);
    else check("lw_cnt", 64'(done_addr.size()), 64'd1);
`endif

    // Slow grant, slow response, then a 4-cycle WB stall.
    gnt_pct = 0; wb_pct = 0; rv_min = 1; rv_max = 1;
    inq.push_back(mk(1, 0, 2'd2, 1, 32'h3000, 0, $urandom));
    repeat (4) step();
    gnt_pct = 100;
    step();
    gnt_pct = 0;
    repeat (6) step();
    wb_pct = 100; gnt_pct = 100;
    run(10);

    // Flush while waiting for load data.
    @(negedge clk);
    ex_valid = 1'b1; ex_ld = 1'b1; ex_st = 1'b0; ex_size = 2'd2; ex_result = 32'h100; ex_rf_we = 1'b1;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; wb_ready = 1'b1;
    #1 check("fl_acc", 64'(ex_ready), 64'd1);
    @(negedge clk);
    ex_valid = 1'b0; dm_gnt = 1'b1;
    #1 check("fl_req", 64'(dm_req), 64'd1);
    @(negedge clk);
    dm_gnt = 1'b0; flush = 1'b1;
    #1 check("fl_gate", 64'({dm_req, wb_valid}), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("fl_drain", 64'({ex_ready, wb_valid}), 64'd0);
    @(negedge clk);
    dm_rvalid = 1'b1;
    #1 check("fl_rv", 64'({ex_ready, wb_valid}), 64'd0);
    @(negedge clk);
    dm_rvalid = 1'b0;
    #1 check("fl_idle", 64'({ex_ready, wb_valid}), 64'b10);

    // Flush withdraws an un-granted request.
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b1; flush = 1'b1; dm_gnt = 1'b1;
    #1 check("flr_gate", 64'(dm_req), 64'd0);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0; dm_gnt = 1'b0;
    #1 check("flr_idle", 64'({ex_ready, dm_req, wb_valid}), 64'b100);

    // Randomized traffic.
    ev_pct = 70; gnt_pct = 50; wb_pct = 70; rv_min = 0; rv_max = 3;
    for (int i = 0; i < 150; i++) inq.push_back(rand_ins());
    run(3000);

    // Reset in the middle of a request.
    gnt_pct = 0; ev_pct = 100;
    inq.push_back(mk(1, 0, 2'd2, 0, 32'h40, 0, 0));
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mrst", 64'({ex_ready, dm_req, wb_valid}), 64'b100);
    inq.delete(); expq.delete(); rv_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
